// File: rtl/matmul_pkg.sv
// Shared defaults, element types and the saturation helper for the small matrix multiplier.
// The helper is only referenced when MATMUL_SAT_EN is defined.
package matmul_pkg;

   localparam int DEFAULT_WIDTH = 16;
   localparam int DEFAULT_N     = 3;

   typedef logic signed [DEFAULT_WIDTH-1:0]   operand_t;
   typedef logic signed [2*DEFAULT_WIDTH-1:0] product_t;

   // Clamp a signed value into the signed range of an out_w-bit word (out_w <= 63).
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                     input int unsigned        out_w);
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      max_v = (64'sd1 <<< (out_w - 32'd1)) - 64'sd1;
      min_v = -max_v - 64'sd1;
      if (value > max_v) begin
         return max_v;
      end else if (value < min_v) begin
         return min_v;
      end else begin
         return value;
      end
   endfunction

endpackage

// File: rtl/mm_dot_product.sv
// One row.column dot product: registered element products, then registered sum.
// MATMUL_SAT_EN selects a widened, saturated sum instead of the 2*WIDTH wrap-around sum.
module mm_dot_product
   import matmul_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int N     = DEFAULT_N
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic signed [WIDTH-1:0]   a_row [N],
   input  logic signed [WIDTH-1:0]   b_col [N],
   output logic signed [2*WIDTH-1:0] result
);

   localparam int PW = 2 * WIDTH;

   logic signed [PW-1:0] p_r [N];
   logic signed [PW-1:0] sum_s;

`ifdef MATMUL_SAT_EN
   localparam int SUM_W = PW + $clog2(N) + 1;
   logic signed [SUM_W-1:0] sum_ext_s;
`endif

   // Product stage: operands are sign-extended first so every product is exact.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N; k++) begin
            p_r[k] <= '0;
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            p_r[k] <= PW'(a_row[k]) * PW'(b_col[k]);
         end
      end
   end

   // Reduce the product registers to one element of the result.
   always_comb begin
`ifdef MATMUL_SAT_EN
      sum_ext_s = '0;
      for (int k = 0; k < N; k++) begin
         sum_ext_s = sum_ext_s + SUM_W'(p_r[k]);
      end
      sum_s = PW'(sat_signed(64'(sum_ext_s), PW));
`else
      sum_s = '0;
      for (int k = 0; k < N; k++) begin
         sum_s = sum_s + p_r[k];
      end
`endif
   end

   // Output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result <= '0;
      end else begin
         result <= sum_s;
      end
   end

endmodule

// File: rtl/matrix_multiplier_small.sv
// Free-running 3-stage pipelined signed N x N matrix multiplier (operand regs, products, sums).
// Optional saturation of each sum is enabled with the MATMUL_SAT_EN macro.
module matrix_multiplier_small
   import matmul_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int N     = DEFAULT_N
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic signed [WIDTH-1:0]   matrixA      [N][N],
   input  logic signed [WIDTH-1:0]   matrixB      [N][N],
   output logic signed [2*WIDTH-1:0] resultMatrix [N][N]
);

   logic signed [WIDTH-1:0] a_r [N][N];
   logic signed [WIDTH-1:0] b_r [N][N];

   // Operand capture stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               a_r[i][j] <= '0;
               b_r[i][j] <= '0;
            end
         end
      end else begin
         a_r <= matrixA;
         b_r <= matrixB;
      end
   end

   // One dot-product unit per result element, fed by row i of A and column j of B.
   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         logic signed [WIDTH-1:0] a_row_s [N];
         logic signed [WIDTH-1:0] b_col_s [N];

         for (genvar k = 0; k < N; k++) begin : g_k
            assign a_row_s[k] = a_r[i][k];
            assign b_col_s[k] = b_r[k][j];
         end

         mm_dot_product #(
            .WIDTH (WIDTH),
            .N     (N)
         ) u_dot (
            .clk    (clk),
            .rst_n  (rst_n),
            .a_row  (a_row_s),
            .b_col  (b_col_s),
            .result (resultMatrix[i][j])
         );
      end
   end

endmodule

// File: tb/tb_matrix_multiplier_small.sv
// Scoreboard bench for matrix_multiplier_small: stimulus pushes expected products tagged with the
// edge after which they must appear; a negedge monitor pops and compares.
module tb_matrix_multiplier_small;
   import matmul_pkg::*;

   localparam int N = 3;

   typedef operand_t op_m_t  [N][N];
   typedef product_t res_m_t [N][N];
   typedef struct {
      res_m_t m;
      int     due;
      string  name;
   } sb_t;

   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   op_m_t  matrixA;
   op_m_t  matrixB;
   res_m_t resultMatrix;

   sb_t sb_q [$];
   int  edge_cnt = 0;
   int  errors = 0;
   int  checks = 0;

   matrix_multiplier_small dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .matrixA      (matrixA),
      .matrixB      (matrixB),
      .resultMatrix (resultMatrix)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic cmp(input string name, input res_m_t exp);
      bit bad;
      bad = 1'b0;
      checks++;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (!bad && resultMatrix[i][j] !== exp[i][j]) begin
               bad = 1'b1;
               $display("FAIL %s [%0d][%0d]: got %0d expected %0d (t=%0t)",
                        name, i, j, resultMatrix[i][j], exp[i][j], $time);
            end
         end
      end
      if (bad) errors++;
   endtask

   task automatic push(input string name, input res_m_t m, input int due);
      sb_t e;
      e.m = m;
      e.due = due;
      e.name = name;
      sb_q.push_back(e);
   endtask

   // Called at a negedge: operands are sampled by the next edge and must show after two more.
   task automatic drive(input string name, input op_m_t a, input op_m_t b, input res_m_t e);
      matrixA = a;
      matrixB = b;
      push(name, e, edge_cnt + 3);
      @(negedge clk);
   endtask

   // Monitor: compare the head entry once its due edge has passed.
   always @(negedge clk) begin : monitor
      sb_t e;
      if (sb_q.size() > 0) begin
         if (sb_q[0].due == edge_cnt) begin
            e = sb_q.pop_front();
            cmp(e.name, e.m);
         end else if (sb_q[0].due < edge_cnt) begin
            e = sb_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: entry due at edge %0d not checked, now edge %0d", e.name, e.due, edge_cnt);
         end
      end
   end

   op_m_t  mat_a, mat_i, mat_2i, mat_3i, mat_ni, mat_bg, mat_min, mat_max;
   res_m_t zero_r, a_r, a2_r, a3_r, g_r, nbg_r, ovf_r, mix_r;

   initial begin
      mat_a   = '{'{16'sd1, 16'sd2, 16'sd3}, '{16'sd4, 16'sd5, 16'sd6}, '{16'sd7, 16'sd8, 16'sd9}};
      mat_bg  = '{'{16'sd9, 16'sd8, 16'sd7}, '{16'sd6, 16'sd5, 16'sd4}, '{16'sd3, 16'sd2, 16'sd1}};
      mat_i   = '{'{16'sd1, 16'sd0, 16'sd0}, '{16'sd0, 16'sd1, 16'sd0}, '{16'sd0, 16'sd0, 16'sd1}};
      mat_2i  = '{'{16'sd2, 16'sd0, 16'sd0}, '{16'sd0, 16'sd2, 16'sd0}, '{16'sd0, 16'sd0, 16'sd2}};
      mat_3i  = '{'{16'sd3, 16'sd0, 16'sd0}, '{16'sd0, 16'sd3, 16'sd0}, '{16'sd0, 16'sd0, 16'sd3}};
      mat_ni  = '{'{-16'sd1, 16'sd0, 16'sd0}, '{16'sd0, -16'sd1, 16'sd0}, '{16'sd0, 16'sd0, -16'sd1}};
      mat_min = '{default: 16'sh8000};
      mat_max = '{default: 16'sd32767};

      zero_r = '{default: 32'sd0};
      a_r    = '{'{32'sd1, 32'sd2, 32'sd3}, '{32'sd4, 32'sd5, 32'sd6}, '{32'sd7, 32'sd8, 32'sd9}};
      a2_r   = '{'{32'sd2, 32'sd4, 32'sd6}, '{32'sd8, 32'sd10, 32'sd12}, '{32'sd14, 32'sd16, 32'sd18}};
      a3_r   = '{'{32'sd3, 32'sd6, 32'sd9}, '{32'sd12, 32'sd15, 32'sd18}, '{32'sd21, 32'sd24, 32'sd27}};
      g_r    = '{'{32'sd30, 32'sd24, 32'sd18}, '{32'sd84, 32'sd69, 32'sd54}, '{32'sd138, 32'sd114, 32'sd90}};
      nbg_r  = '{'{-32'sd9, -32'sd8, -32'sd7}, '{-32'sd6, -32'sd5, -32'sd4}, '{-32'sd3, -32'sd2, -32'sd1}};
`ifdef MATMUL_SAT_EN
      ovf_r  = '{default: 32'sd2147483647};
      mix_r  = '{default: 32'sh80000000};
`else
      ovf_r  = '{default: -32'sd1073741824};
      mix_r  = '{default: 32'sd1073840128};
`endif

      // Reset held with nonzero operands: outputs stay zero.
      matrixA = mat_a;
      matrixB = mat_bg;
      rst_n = 1'b0;
      repeat (4) begin
         @(negedge clk);
         cmp("reset_hold", zero_r);
      end

      // Release: two zero outputs, then the first sampled product.
      rst_n = 1'b1;
      push("post_release_e1", zero_r, edge_cnt + 1);
      push("post_release_e2", zero_r, edge_cnt + 2);
      drive("identity_0", mat_a, mat_i, a_r);
      drive("identity_1", mat_a, mat_i, a_r);
      drive("identity_2", mat_a, mat_i, a_r);
      drive("general", mat_a, mat_bg, g_r);
      drive("overflow_min", mat_min, mat_min, ovf_r);
      drive("overflow_mix", mat_max, mat_min, mix_r);
      drive("neg_identity", mat_ni, mat_bg, nbg_r);
      drive("stream_1i", mat_a, mat_i, a_r);
      drive("stream_2i", mat_a, mat_2i, a2_r);
      drive("stream_3i", mat_a, mat_3i, a3_r);

      // Reset between edges with results in flight: outputs clear at once.
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 cmp("async_reset", zero_r);
      sb_q.delete();
      @(negedge clk);
      cmp("reset_low_neg", zero_r);
      rst_n = 1'b1;
      push("restart_e1", zero_r, edge_cnt + 1);
      push("restart_e2", zero_r, edge_cnt + 2);
      drive("restart_general", mat_a, mat_bg, g_r);

      repeat (6) @(negedge clk);
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d entries unchecked, required 0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
